// File: rtl/spi_param_port.sv
// SPI slave port that streams framed parameter words out of a memory on MISO and writes
// framed words received on MOSI back into memory. Optional error counter: SPI_PARAM_PORT_ERRCNT_EN.
module spi_param_port #(
  parameter int PARAM_WIDTH = 36,
  parameter int CHUNK_WIDTH = 18,
  parameter int ADDR_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_SCLK,
  input  logic                   spi_SSEL,
  input  logic                   spi_MOSI,
  output logic                   spi_MISO,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [PARAM_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PARAM_WIDTH-1:0] wr_data,
  output logic                   wr_enable,
  output logic                   valid,
  output logic [ERR_WIDTH-1:0]   err_count
);

  localparam int NCHUNK      = PARAM_WIDTH / CHUNK_WIDTH;
  localparam int PACKET_SIZE = PARAM_WIDTH + 2 * NCHUNK;
  localparam int SEG         = CHUNK_WIDTH + 2;
  localparam int CNT_W       = $clog2(PACKET_SIZE);
  localparam logic CPOL_L    = (CPOL != 0);

  if (PARAM_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
    $error("PARAM_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PRELOAD, ST_SHIFT} state_e;

  function automatic logic [PACKET_SIZE-1:0] frame_word(input logic [PARAM_WIDTH-1:0] w);
    logic [PACKET_SIZE-1:0] f;
    f = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      f[PACKET_SIZE-1-i*SEG -: 2] = (i == 0) ? 2'b01 : 2'b10;
      f[PACKET_SIZE-3-i*SEG -: CHUNK_WIDTH] = w[PARAM_WIDTH-1-i*CHUNK_WIDTH -: CHUNK_WIDTH];
    end
    return f;
  endfunction

  function automatic logic frame_ok(input logic [PACKET_SIZE-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NCHUNK; i++) begin
      if (p[PACKET_SIZE-1-i*SEG -: 2] != ((i == 0) ? 2'b01 : 2'b10)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [PARAM_WIDTH-1:0] payload_of(input logic [PACKET_SIZE-1:0] p);
    logic [PARAM_WIDTH-1:0] pl;
    pl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      pl[PARAM_WIDTH-1-i*CHUNK_WIDTH -: CHUNK_WIDTH] = p[PACKET_SIZE-3-i*SEG -: CHUNK_WIDTH];
    end
    return pl;
  endfunction

  // Synchronizers; the third SCLK/SSEL stage is edge-detect history.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ssel_sync_q, ssel_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_SCLK};
    ssel_sync_d = {ssel_sync_q[1:0], spi_SSEL};
    mosi_sync_d = {mosi_sync_q[0], spi_MOSI};
  end

  // SSEL history resets to "asserted" so a select held low across reset never looks like a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {3{CPOL_L}};
      ssel_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ssel_sync_q <= ssel_sync_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  logic sclk_cur, sclk_prev, lead, trail, ssel_now, ssel_fall, mosi_s;
  assign sclk_cur  = sclk_sync_q[1] ^ CPOL_L;
  assign sclk_prev = sclk_sync_q[2] ^ CPOL_L;
  assign lead      = sclk_cur & ~sclk_prev;
  assign trail     = ~sclk_cur & sclk_prev;
  assign ssel_now  = ssel_sync_q[1];
  assign ssel_fall = ssel_sync_q[2] & ~ssel_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  state_e                 state_q, state_d;
  logic                   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PACKET_SIZE-2:0] rx_q, rx_d;
  logic [PACKET_SIZE-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  pkt_idx_q, pkt_idx_d;
  logic [PARAM_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   valid_q, valid_d;
  logic [1:0]             reload_q, reload_d;
  logic [PACKET_SIZE-1:0] rx_pkt;
  logic                   pkt_done, pkt_good;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    pkt_idx_d = pkt_idx_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    valid_d   = valid_q;
    reload_d  = {reload_q[0], 1'b0};
    pkt_done  = 1'b0;
    pkt_good  = 1'b0;
    rx_pkt    = {rx_q, mosi_s};
    case (state_q)
      ST_IDLE: begin
        rd_addr_d = '0;
        pkt_idx_d = '0;
        bit_cnt_d = '0;
        rx_d      = '0;
        tx_d      = '0;
        reload_d  = 2'b00;
        pre_cnt_d = 1'b0;
        if (ssel_fall) state_d = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        pre_cnt_d = 1'b1;
        if (ssel_now) begin
          state_d = ST_IDLE;
        end else if (pre_cnt_q) begin
          tx_d    = frame_word(rd_data);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ssel_now) begin
          state_d = ST_IDLE;
        end else begin
          if (lead) begin
            rx_d = rx_pkt[PACKET_SIZE-2:0];
            if (bit_cnt_q == CNT_W'(PACKET_SIZE - 1)) begin
              bit_cnt_d = '0;
              pkt_done  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // The trailing edge right after a completed packet must not shift: the reload
          // has already placed the next packet's MSB on MISO.
          if (reload_q[1]) begin
            tx_d = frame_word(rd_data);
          end else if (trail && bit_cnt_q != '0) begin
            tx_d = {tx_q[PACKET_SIZE-2:0], 1'b0};
          end
          if (pkt_done) begin
            rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
            reload_d[0] = 1'b1;
            wr_addr_d   = pkt_idx_q;
            pkt_idx_d   = pkt_idx_q + ADDR_WIDTH'(1);
            pkt_good    = frame_ok(rx_pkt);
            valid_d     = pkt_good;
            if (pkt_good) begin
              wr_en_d   = 1'b1;
              wr_data_d = payload_of(rx_pkt);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= 1'b0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      pkt_idx_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      reload_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      pkt_idx_q <= pkt_idx_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      valid_q   <= valid_d;
      reload_q  <= reload_d;
    end
  end

`ifdef SPI_PARAM_PORT_ERRCNT_EN
  logic [ERR_WIDTH-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pkt_done && !pkt_good && err_q != '1) err_d = err_q + ERR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign spi_MISO  = (state_q != ST_IDLE) && tx_q[PACKET_SIZE-1];
  assign rd_addr   = rd_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_enable = wr_en_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_spi_param_port.sv
// Bench for spi_param_port: three instances (default, narrow address/error widths,
// CPOL=1 with 8-bit chunks) driven by a bit-level SPI master, writes checked against a queue.
module tb_spi_param_port;
  localparam int HALF = 6;
  localparam int W    = 44;
`ifdef SPI_PARAM_PORT_ERRCNT_EN
  localparam int ERRC = 1;
`else
  localparam int ERRC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic sclk [3];
  logic ssel [3];
  logic mosi [3];
  logic miso [3];

  logic [7:0]  rd_addr0, wr_addr0, err0;
  logic [35:0] rd_data0, wr_data0;
  logic        wr_en0, valid0;
  logic [1:0]  rd_addr1, wr_addr1, err1;
  logic [35:0] wr_data1;
  logic        wr_en1, valid1;
  logic [7:0]  rd_addr2, wr_addr2, err2;
  logic [31:0] wr_data2;
  logic        wr_en2, valid2;

  logic [35:0] mem [256];
  always @(posedge clk) rd_data0 <= mem[rd_addr0];

  spi_param_port dut0 (
    .clk(clk), .rst_n(rst_n), .spi_SCLK(sclk[0]), .spi_SSEL(ssel[0]), .spi_MOSI(mosi[0]),
    .spi_MISO(miso[0]), .rd_addr(rd_addr0), .rd_data(rd_data0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .wr_enable(wr_en0), .valid(valid0), .err_count(err0)
  );

  spi_param_port #(.ADDR_WIDTH(2), .ERR_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_SCLK(sclk[1]), .spi_SSEL(ssel[1]), .spi_MOSI(mosi[1]),
    .spi_MISO(miso[1]), .rd_addr(rd_addr1), .rd_data(36'h0), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .wr_enable(wr_en1), .valid(valid1), .err_count(err1)
  );

  spi_param_port #(.CPOL(1), .PARAM_WIDTH(32), .CHUNK_WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .spi_SCLK(sclk[2]), .spi_SSEL(ssel[2]), .spi_MOSI(mosi[2]),
    .spi_MISO(miso[2]), .rd_addr(rd_addr2), .rd_data(32'h0), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_enable(wr_en2), .valid(valid2), .err_count(err2)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [39:0] mk36(input logic [35:0] w);
    return {2'b01, w[35:18], 2'b10, w[17:0]};
  endfunction

  function automatic logic [39:0] mk32(input logic [31:0] w);
    return {2'b01, w[31:24], 2'b10, w[23:16], 2'b10, w[15:8], 2'b10, w[7:0]};
  endfunction

  // Scoreboard side: each observed write pops the oldest expected {addr, data}.
  task automatic sb_got(input int d, input logic prev, input logic [W-1:0] got);
    logic [W-1:0] e;
    int sz;
    chk($sformatf("wr%0d_pulse_len", d), {63'b0, prev}, 64'd0);
    sz = (d == 0) ? exp_q0.size() : (d == 1) ? exp_q1.size() : exp_q2.size();
    chk($sformatf("wr%0d_expected", d), {63'b0, sz != 0}, 64'd1);
    if (sz != 0) begin
      case (d)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("wr%0d_addr_data", d), 64'(got), 64'(e));
    end
  endtask

  task automatic sb_empty(input int d);
    int sz;
    sz = (d == 0) ? exp_q0.size() : (d == 1) ? exp_q1.size() : exp_q2.size();
    chk($sformatf("sb%0d_drained", d), 64'(sz), 64'd0);
  endtask

  logic wr_en0_prev = 1'b0, wr_en1_prev = 1'b0, wr_en2_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_en0) sb_got(0, wr_en0_prev, {wr_addr0, wr_data0});
    if (wr_en1) sb_got(1, wr_en1_prev, {6'b0, wr_addr1, wr_data1});
    if (wr_en2) sb_got(2, wr_en2_prev, {wr_addr2, 4'h0, wr_data2});
    wr_en0_prev = wr_en0;
    wr_en1_prev = wr_en1;
    wr_en2_prev = wr_en2;
  end

  // SPI master: MOSI set on the trailing edge, MISO sampled just before the leading edge.
  task automatic spi_xfer(input int d, input logic [39:0] tx, input int n, output logic [39:0] rx);
    logic cp;
    cp = (d == 2);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi[d] = tx[39-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[38:0], miso[d]};
      sclk[d] = ~cp;
      repeat (HALF) @(negedge clk);
      sclk[d] = cp;
    end
  endtask

  task automatic send(input int d, input logic [39:0] tx);
    logic [39:0] rx;
    spi_xfer(d, tx, 40, rx);
  endtask

  task automatic start(input int d);
    ssel[d] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic stop(input int d);
    repeat (4) @(negedge clk);
    ssel[d] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [39:0] rx;
    logic [35:0] w;
    logic [31:0] w32;
    logic [1:0]  m;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sclk[d] = (d == 2);
      ssel[d] = 1'b1;
      mosi[d] = 1'b0;
    end
    for (int a = 0; a < 256; a++) mem[a] = 36'({$urandom(), $urandom()});
    mem[0] = 36'h123456789;
    mem[1] = 36'hFEDCBA987;
    repeat (3) @(negedge clk);

    chk("rst_wr_en", 64'(wr_en0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr0), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr0), 64'd0);
    chk("rst_wr_data", 64'(wr_data0), 64'd0);
    chk("rst_miso", 64'(miso[0]), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single known packet
    start(0);
    exp_q0.push_back({8'd0, 36'hAAAA95555});
    send(0, {2'b01, 18'h2AAAA, 2'b10, 18'h15555});
    repeat (4) @(negedge clk);
    chk("pkt1_valid", 64'(valid0), 64'd1);
    chk("pkt1_wr_addr", 64'(wr_addr0), 64'd0);
    chk("pkt1_wr_data", 64'(wr_data0), 64'hAAAA95555);
    stop(0);
    chk("idle_miso", 64'(miso[0]), 64'd0);
    chk("idle_rd_addr", 64'(rd_addr0), 64'd0);
    sb_empty(0);

    // Two packets while reading back memory words 0 and 1
    start(0);
    for (int k = 0; k < 2; k++) begin
      w = 36'({$urandom(), $urandom()});
      exp_q0.push_back({8'(k), w});
      spi_xfer(0, mk36(w), 40, rx);
      chk($sformatf("miso_word%0d", k), 64'(rx), 64'(mk36(k == 0 ? 36'h123456789 : 36'hFEDCBA987)));
    end
    repeat (4) @(negedge clk);
    chk("rd_addr_after2", 64'(rd_addr0), 64'd2);
    stop(0);
    sb_empty(0);

    // Bad chunk-1 marker, then a good packet in the same transaction
    start(0);
    send(0, {2'b01, 18'h31234, 2'b11, 18'h0ABCD});
    repeat (4) @(negedge clk);
    chk("bad1_valid", 64'(valid0), 64'd0);
    chk("bad1_err", 64'(err0), 64'(ERRC));
    w = 36'({$urandom(), $urandom()});
    exp_q0.push_back({8'd1, w});
    send(0, mk36(w));
    repeat (4) @(negedge clk);
    chk("after_bad_valid", 64'(valid0), 64'd1);
    stop(0);
    sb_empty(0);

    // Abort after 23 bits: nothing written, valid/err held
    start(0);
    w = 36'({$urandom(), $urandom()});
    spi_xfer(0, mk36(w), 23, rx);
    stop(0);
    chk("abort_valid", 64'(valid0), 64'd1);
    chk("abort_err", 64'(err0), 64'(ERRC));
    sb_empty(0);
    start(0);
    w = 36'({$urandom(), $urandom()});
    exp_q0.push_back({8'd0, w});
    send(0, mk36(w));
    stop(0);
    sb_empty(0);

    // Bad chunk-0 marker
    start(0);
    send(0, {2'b10, 18'h00001, 2'b10, 18'h3FFFF});
    stop(0);
    chk("bad0_valid", 64'(valid0), 64'd0);
    chk("bad0_err", 64'(err0), 64'(2 * ERRC));

    // Narrow address wrap and saturating error counter
    start(1);
    for (int k = 0; k < 5; k++) begin
      w = 36'({$urandom(), $urandom()});
      exp_q1.push_back({8'(k % 4), w});
      send(1, mk36(w));
    end
    stop(1);
    chk("wrap_valid", 64'(valid1), 64'd1);
    sb_empty(1);
    start(1);
    for (int k = 0; k < 5; k++) begin
      m = 2'($urandom_range(0, 2));
      if (m == 2'b01) m = 2'b11;
      send(1, {m, 18'($urandom()), 2'b10, 18'($urandom())});
    end
    stop(1);
    chk("sat_err", 64'(err1), 64'(ERRC != 0 ? 3 : 0));
    chk("sat_valid", 64'(valid1), 64'd0);
    chk("sat_wr_addr", 64'(wr_addr1), 64'd0);
    sb_empty(1);

    // CPOL=1, 8-bit chunks, reset mid-packet
    start(2);
    w32 = $urandom();
    exp_q2.push_back({8'd0, 36'(w32)});
    send(2, mk32(w32));
    spi_xfer(2, mk32($urandom()), 20, rx);
    rst_n = 1'b0;
    #1;
    chk("r2_rd_addr", 64'(rd_addr2), 64'd0);
    chk("r2_wr_addr", 64'(wr_addr2), 64'd0);
    chk("r2_wr_data", 64'(wr_data2), 64'd0);
    chk("r2_wr_en", 64'(wr_en2), 64'd0);
    chk("r2_valid", 64'(valid2), 64'd0);
    chk("r2_err", 64'(err2), 64'd0);
    chk("r2_miso", 64'(miso[2]), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // SSEL still low from before reset: this packet must be ignored
    send(2, mk32($urandom()));
    repeat (4) @(negedge clk);
    chk("held_sel_valid", 64'(valid2), 64'd0);
    stop(2);
    sb_empty(2);
    start(2);
    w32 = $urandom();
    exp_q2.push_back({8'd0, 36'(w32)});
    send(2, mk32(w32));
    repeat (4) @(negedge clk);
    chk("cpol1_valid", 64'(valid2), 64'd1);
    chk("cpol1_wr_data", 64'(wr_data2), 64'(w32));
    stop(2);
    sb_empty(2);
    sb_empty(0);
    sb_empty(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_param_port.md
SPI_PARAM_PORT -- requirements
Module: spi_param_port

Interface
REQ-001 SHALL have parameter PARAM_WIDTH, default 36: memory word width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 18: payload bits per framed chunk; PARAM_WIDTH SHALL be a multiple of it (elaboration error otherwise).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: memory address width.
REQ-004 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-005 SHALL have parameter ERR_WIDTH, default 8: frame-error counter width.
REQ-006 Ports, name direction width meaning:
- clk  in  1  system clock; all logic synchronous to its rising edge
- rst_n  in  1  asynchronous active-low reset
- spi_SCLK  in  1  SPI clock (asynchronous)
- spi_SSEL  in  1  SPI select, active-low (asynchronous)
- spi_MOSI  in  1  SPI data in (asynchronous)
- spi_MISO  out  1  SPI data out
- rd_addr  out  ADDR_WIDTH  memory read address
- rd_data  in  PARAM_WIDTH  read data, valid one clk after rd_addr
- wr_addr  out  ADDR_WIDTH  memory write address
- wr_data  out  PARAM_WIDTH  memory write data
- wr_enable  out  1  one-cycle write strobe
- valid  out  1  last completed packet had correct framing
- err_count  out  ERR_WIDTH  saturating framing-error count

Function
REQ-007 SHALL pass spi_SCLK, spi_SSEL and spi_MOSI through 2-flop synchronizers before use; SCLK edges are detected from the synchronized value.
REQ-008 NCHUNK = PARAM_WIDTH/CHUNK_WIDTH; packet = NCHUNK chunks of {2-bit marker, CHUNK_WIDTH payload}, MSB first; PACKET_SIZE = PARAM_WIDTH + 2*NCHUNK.
REQ-009 Marker of chunk 0 (most significant) SHALL be 2'b01; marker of every later chunk SHALL be 2'b10.
REQ-010 Leading edge = rising if CPOL=0, falling if CPOL=1; MOSI SHALL be sampled on the leading edge and MISO SHALL shift on the trailing edge.
REQ-011 States IDLE (SSEL high), PRELOAD (SSEL asserted, outgoing packet being loaded), SHIFT (counting bits); IDLE->PRELOAD on SSEL assertion, PRELOAD->SHIFT after 2 clk, SHIFT->IDLE on SSEL deassertion.
REQ-012 In IDLE, rd_addr SHALL be 0; in PRELOAD the framed rd_data for address 0 SHALL be loaded so its MSB is on spi_MISO before the first leading edge.
REQ-013 On the PACKET_SIZE-th leading edge, the packet SHALL be complete; bit counter reloads and the next packet begins with no gap.
REQ-014 At packet completion rd_addr SHALL increment (wrapping 2^ADDR_WIDTH-1 -> 0) and the framed word for the new address SHALL be loaded into the output shifter within 3 clk, before the next trailing edge.
REQ-015 At packet completion, valid SHALL update 1 clk later; if framing is correct, wr_data = concatenated payloads and wr_enable SHALL pulse for exactly 1 clk in the same cycle.
REQ-016 wr_addr SHALL equal the index of the completed packet within the transaction (0 for first), wrapping like rd_addr; it SHALL advance on every completed packet, valid or not.
REQ-017 An invalid packet SHALL produce no write; err_count SHALL increment by 1, saturating at all-ones.
REQ-018 SSEL deassertion mid-packet SHALL discard the partial packet (no write, no error count) and return to IDLE; valid and err_count SHALL hold.
REQ-019 SCLK edges while in IDLE or PRELOAD SHALL be ignored.
REQ-020 spi_MISO SHALL be 0 in IDLE.

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, rd_addr 0, wr_addr 0, wr_data 0, wr_enable 0, valid 0, err_count 0, shifters 0, spi_MISO 0.
REQ-022 Reset deassertion during an active SSEL SHALL wait for the next SSEL deassertion before accepting a transaction.

Configuration
REQ-023 Macro SPI_PARAM_PORT_ERRCNT_EN: when defined, err_count behaves per REQ-017; when undefined, the counter logic SHALL be omitted and err_count SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-024 Defaults, SSEL low, one 40-bit packet 01|0x2AAAA|10|0x15555 -> wr_enable 1 clk, wr_addr 0, wr_data 0xAAAA95555, valid 1.
REQ-025 Memory preset addr0=0x123456789, addr1=0xFEDCBA987; 80 clocks -> MISO returns the framed forms of both words; rd_addr 2 at end.
REQ-026 Packet with chunk-1 marker 2'b11 -> no wr_enable, valid 0, err_count 1; next valid packet writes wr_addr 1.
REQ-027 SSEL deasserted after 23 bits -> no write, err_count unchanged; new transaction writes wr_addr 0.
REQ-028 ADDR_WIDTH=2, 5 valid packets -> writes to addresses 0,1,2,3,0; with ERR_WIDTH=2, 5 bad packets -> err_count 3.
REQ-029 CPOL=1, PARAM_WIDTH=32, CHUNK_WIDTH=8, rst_n pulsed mid-packet -> all outputs 0 immediately; subsequent 40-bit packet writes correctly.
